// File: rtl/oversampling_edge_generator.sv
// Square-wave synthesiser: one WORD_BITS-wide word per CLK, with edge flag/index in detector format.
// Optional OVS_EDGE_GEN_FRAC_EN: low 8 bits of each half-period are a fraction of a bit-time.
module oversampling_edge_generator #(
    parameter int WORD_BITS   = 64,
    parameter int PERIOD_BITS = 24
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         ENABLE,
    input  logic [PERIOD_BITS-1:0]       HALF_PERIOD_LOW,
    input  logic [PERIOD_BITS-1:0]       HALF_PERIOD_HIGH,
    output logic [WORD_BITS-1:0]         PARALLEL_OUT,
    output logic                         CHANGED_FLAG,
    output logic [$clog2(WORD_BITS)-1:0] CHANGED_BIT,
    output logic                         LEVEL,
    output logic                         fsm_state
);
    localparam int BIT_W = $clog2(WORD_BITS);
    localparam int REM_W = PERIOD_BITS + 1;
    localparam logic [REM_W-1:0] WB_REM = REM_W'(WORD_BITS);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [REM_W-1:0]       rem_q, rem_d;
    logic                   level_q, level_d;
    logic [WORD_BITS-1:0]   word_q, word_d;
    logic                   flag_q, flag_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [PERIOD_BITS-1:0] sel_half;
    logic [REM_W-1:0]       int_part;
    logic [REM_W-1:0]       phase_len;
    logic [WORD_BITS-1:0]   ones;
    logic [WORD_BITS-1:0]   mask;

`ifdef OVS_EDGE_GEN_FRAC_EN
    logic [7:0] acc_q, acc_d, acc_base, acc_sum;
    logic       carry;
`endif

    // Length of the phase starting now: low at start or when leaving high, high otherwise.
    always_comb begin
        sel_half = (state_q == IDLE || level_q) ? HALF_PERIOD_LOW : HALF_PERIOD_HIGH;
`ifdef OVS_EDGE_GEN_FRAC_EN
        acc_base          = (state_q == IDLE) ? 8'd0 : acc_q;
        {carry, acc_sum}  = {1'b0, acc_base} + {1'b0, sel_half[7:0]};
        int_part          = REM_W'(sel_half[PERIOD_BITS-1:8]);
        phase_len         = ((int_part < WB_REM) ? WB_REM : int_part) + REM_W'(carry);
`else
        int_part          = REM_W'(sel_half);
        phase_len         = (int_part < WB_REM) ? WB_REM : int_part;
`endif
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        level_d = level_q;
        word_d  = '0;
        flag_d  = 1'b0;
        bit_d   = '0;
        ones    = '1;
        mask    = ones << rem_q[BIT_W-1:0];
`ifdef OVS_EDGE_GEN_FRAC_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            IDLE: begin
                // A high level left over from RUN falls at bit 0 of this zero word.
                flag_d  = level_q;
                level_d = 1'b0;
                if (ENABLE) begin
                    state_d = RUN;
                    rem_d   = phase_len;
`ifdef OVS_EDGE_GEN_FRAC_EN
                    acc_d   = acc_sum;
`endif
                end
            end
            RUN: begin
                if (rem_q >= WB_REM) begin
                    word_d = {WORD_BITS{level_q}};
                    rem_d  = rem_q - WB_REM;
                end else begin
                    word_d  = level_q ? ~mask : mask;
                    flag_d  = 1'b1;
                    bit_d   = rem_q[BIT_W-1:0];
                    level_d = ~level_q;
                    rem_d   = rem_q + phase_len - WB_REM;
`ifdef OVS_EDGE_GEN_FRAC_EN
                    acc_d   = acc_sum;
`endif
                end
                if (!ENABLE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            rem_q   <= '0;
            level_q <= 1'b0;
            word_q  <= '0;
            flag_q  <= 1'b0;
            bit_q   <= '0;
`ifdef OVS_EDGE_GEN_FRAC_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            level_q <= level_d;
            word_q  <= word_d;
            flag_q  <= flag_d;
            bit_q   <= bit_d;
`ifdef OVS_EDGE_GEN_FRAC_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign PARALLEL_OUT = word_q;
    assign CHANGED_FLAG = flag_q;
    assign CHANGED_BIT  = bit_q;
    assign LEVEL        = level_q;
    assign fsm_state    = state_q;
endmodule

// File: tb/tb_oversampling_edge_generator.sv
// Directed + randomised bench for oversampling_edge_generator against a bit-stream reference model.
module tb_oversampling_edge_generator;
    localparam int WB = 64;
    localparam int PB = 24;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          ENABLE = 1'b0;
    logic [PB-1:0] HALF_PERIOD_LOW = '0;
    logic [PB-1:0] HALF_PERIOD_HIGH = '0;
    logic [WB-1:0] PARALLEL_OUT;
    logic          CHANGED_FLAG;
    logic [5:0]    CHANGED_BIT;
    logic          LEVEL;
    logic          fsm_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    // Reference model: the waveform as a stream of bit-times.
    bit m_run   = 1'b0;
    bit m_level = 1'b0;
    int m_left  = 0;

    oversampling_edge_generator #(.WORD_BITS(WB), .PERIOD_BITS(PB)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
        .HALF_PERIOD_LOW(HALF_PERIOD_LOW), .HALF_PERIOD_HIGH(HALF_PERIOD_HIGH),
        .PARALLEL_OUT(PARALLEL_OUT), .CHANGED_FLAG(CHANGED_FLAG),
        .CHANGED_BIT(CHANGED_BIT), .LEVEL(LEVEL), .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    function automatic int clamp(input int v);
        return (v < WB) ? WB : v;
    endfunction

    task automatic check_val(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Produces the expected outputs for the cycle whose inputs are currently applied.
    task automatic model_step(output logic [WB-1:0] w, output logic f, output logic [5:0] b, output logic l);
        w = '0; f = 1'b0; b = '0;
        if (!m_run) begin
            f = m_level;
            m_level = 1'b0;
            if (ENABLE) begin
                m_run  = 1'b1;
                m_left = clamp(int'(HALF_PERIOD_LOW));
            end
        end else begin
            for (int i = 0; i < WB; i++) begin
                if (m_left == 0) begin
                    m_level = ~m_level;
                    m_left  = clamp(int'(m_level ? HALF_PERIOD_HIGH : HALF_PERIOD_LOW));
                    f = 1'b1;
                    b = 6'(i);
                end
                w[i] = m_level;
                m_left--;
            end
            if (!ENABLE) m_run = 1'b0;
        end
        l = m_level;
    endtask

    task automatic step_cycle(input string tag);
        logic [WB-1:0] ew;
        logic ef, el;
        logic [5:0] eb;
        model_step(ew, ef, eb, el);
        @(posedge CLK);
        #1;
        check_val({tag, "_word"}, PARALLEL_OUT, ew);
        check_val({tag, "_flag"}, WB'(CHANGED_FLAG), WB'(ef));
        check_val({tag, "_bit"}, WB'(CHANGED_BIT), WB'(eb));
        check_val({tag, "_level"}, WB'(LEVEL), WB'(el));
    endtask

    task automatic run_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) step_cycle(tag);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_word"}, PARALLEL_OUT, '0);
        check_val({tag, "_flag"}, WB'(CHANGED_FLAG), '0);
        check_val({tag, "_bit"}, WB'(CHANGED_BIT), '0);
        check_val({tag, "_level"}, WB'(LEVEL), '0);
    endtask

    initial begin
        #1 RESET = 1'b1;
        #12;
        check_zero("reset");
        @(posedge CLK);
        #1 RESET = 1'b0;

        // 100/100: straddling edges at bits 36 and 8.
        HALF_PERIOD_LOW = 24'd100; HALF_PERIOD_HIGH = 24'd100; ENABLE = 1'b1;
        run_cycles("p100", 12);
        ENABLE = 1'b0;
        run_cycles("p100_off", 3);

        // Exactly one word per phase: every edge on a word boundary.
        HALF_PERIOD_LOW = 24'd64; HALF_PERIOD_HIGH = 24'd64; ENABLE = 1'b1;
        run_cycles("p64", 9);
        ENABLE = 1'b0;
        run_cycles("p64_off", 3);

        // Clamp: 10 and 0 behave as 64.
        HALF_PERIOD_LOW = 24'd10; HALF_PERIOD_HIGH = 24'd0; ENABLE = 1'b1;
        run_cycles("clamp", 9);
        ENABLE = 1'b0;
        run_cycles("clamp_off", 3);

        // Mid-phase change of HIGH must only affect the following high phase.
        HALF_PERIOD_LOW = 24'd150; HALF_PERIOD_HIGH = 24'd70; ENABLE = 1'b1;
        run_cycles("latch", 4);
        HALF_PERIOD_HIGH = 24'd200;
        run_cycles("latch_mid", 16);

        // Asynchronous reset between clock edges.
        #2 RESET = 1'b1;
        #1;
        check_zero("async_rst");
        #2 RESET = 1'b0;
        m_run = 1'b0; m_level = 1'b0; m_left = 0;
        HALF_PERIOD_LOW = 24'd90; HALF_PERIOD_HIGH = 24'd130;
        run_cycles("after_rst", 10);

        // Random periods, random input changes and enable drop-outs.
        for (int seg = 0; seg < 12; seg++) begin
            for (int c = 0; c < 30; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    HALF_PERIOD_LOW  = PB'($urandom_range(0, 300));
                    HALF_PERIOD_HIGH = PB'($urandom_range(0, 300));
                end
                ENABLE = ($urandom_range(0, 9) != 0);
                step_cycle("rand");
            end
        end

        ENABLE = 1'b0;
        run_cycles("final_off", 3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
